// File: rtl/bip_run_controller.sv
// bip_run_controller
//   Host-side sequencer for the BIP core. A byte stream from the UART receiver either loads
//   program memory ('L', 16-bit word count, then lo/hi byte pairs) or starts a run ('R').
//   During a run the core is released from reset and its cycles are counted until it halts
//   or the timeout expires. A 7-byte report is then sent to the UART transmitter:
//   status, cnt[7:0], cnt[15:8], cnt[23:16], cnt[31:24], acc[7:0], acc[15:8].
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   i_rx_data    received byte, qualified by i_rx_valid (1-cycle strobe, no backpressure)
//   o_tx_data    byte to transmit, held from o_tx_start until the transmitter goes idle
//   o_tx_start   1-cycle start pulse to the transmitter
//   i_tx_busy    transmitter busy
//   o_pm_we      program-memory write enable (1-cycle pulse)
//   o_pm_addr    program-memory write address (holds its last value)
//   o_pm_wdata   program-memory write data (holds its last value)
//   o_bip_rst    active-low reset to the BIP core, high only while the core runs
//   i_bip_done   BIP halt flag
//   i_acc        BIP accumulator
//   o_busy       high in every state except IDLE
//   o_dbg_state  current FSM state, for observation only
//
// Handshake: the transmitter sees o_tx_start for exactly one cycle with o_tx_data already
// valid; it raises i_tx_busy the cycle after, and the next byte goes out only once
// i_tx_busy is low again. Receive bytes are never stalled; unexpected ones are dropped.
module bip_run_controller #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_busy,
    output logic              o_pm_we,
    output logic [ADDR_W-1:0] o_pm_addr,
    output logic [DATA_W-1:0] o_pm_wdata,
    output logic              o_bip_rst,
    input  logic              i_bip_done,
    input  logic [DATA_W-1:0] i_acc,
    output logic              o_busy,
    output logic [3:0]        o_dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_LO  = 4'd1,
        S_LEN_HI  = 4'd2,
        S_DATA_LO = 4'd3,
        S_DATA_HI = 4'd4,
        S_PM_WR   = 4'd5,
        S_RUN     = 4'd6,
        S_REPORT  = 4'd7,
        S_TX_WAIT = 4'd8
    } state_t;

    localparam logic [7:0]    CMD_LOAD  = 8'h4C;
    localparam logic [7:0]    CMD_RUN   = 8'h52;
    localparam logic [15:0]   PM_DEPTH  = 16'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [2:0]    LAST_BYTE = 3'd6;

    state_t              state_q, state_d;
    logic [7:0]          len_lo_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [7:0]          lo_q;
    logic [ADDR_W-1:0]   pm_addr_q;
    logic [DATA_W-1:0]   pm_wdata_q;
    logic [CNT_W-1:0]    counter_q;
    logic [7:0]          status_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   acc_q;
    logic [2:0]          byte_idx_q;
    logic [7:0]          tx_data_q;
    logic                tx_start_q;
    logic                bip_rst_q;

    logic [15:0]         len_word;
    logic [ADDR_W:0]     len_sat;
    logic                last_word;
    logic                run_capture;
    logic                timed_out;
    logic [7:0]          rpt_byte;

    assign len_word    = {i_rx_data, len_lo_q};
    assign len_sat     = (len_word > PM_DEPTH) ? PM_DEPTH[ADDR_W:0] : len_word[ADDR_W:0];
    assign last_word   = ({1'b0, idx_q} == (len_q - LEN_ONE));
    assign timed_out   = (counter_q == CNT_W'(TIMEOUT));
    assign run_capture = (state_q == S_RUN) && (i_bip_done || timed_out);

    always_comb begin
        rpt_byte = status_q;
        case (byte_idx_q)
            3'd0:    rpt_byte = status_q;
            3'd1:    rpt_byte = cnt_q[7:0];
            3'd2:    rpt_byte = cnt_q[15:8];
            3'd3:    rpt_byte = cnt_q[23:16];
            3'd4:    rpt_byte = cnt_q[31:24];
            3'd5:    rpt_byte = acc_q[7:0];
            3'd6:    rpt_byte = acc_q[15:8];
            default: rpt_byte = status_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_rx_valid && i_rx_data == CMD_LOAD)     state_d = S_LEN_LO;
                else if (i_rx_valid && i_rx_data == CMD_RUN) state_d = S_RUN;
            end
            S_LEN_LO:  if (i_rx_valid) state_d = S_LEN_HI;
            S_LEN_HI:  if (i_rx_valid) state_d = (len_word == 16'd0) ? S_IDLE : S_DATA_LO;
            S_DATA_LO: if (i_rx_valid) state_d = S_DATA_HI;
            S_DATA_HI: if (i_rx_valid) state_d = S_PM_WR;
            S_PM_WR:   state_d = last_word ? S_IDLE : S_DATA_LO;
            S_RUN:     if (run_capture) state_d = S_REPORT;
            S_REPORT:  if (!i_tx_busy) state_d = S_TX_WAIT;
            // tx_start_q marks the first TX_WAIT cycle, before the transmitter has reacted.
            S_TX_WAIT: begin
                if (!tx_start_q && !i_tx_busy)
                    state_d = (byte_idx_q == LAST_BYTE) ? S_IDLE : S_REPORT;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        o_pm_we     = (state_q == S_PM_WR);
        o_busy      = (state_q != S_IDLE);
        o_dbg_state = state_q;
        o_pm_addr   = pm_addr_q;
        o_pm_wdata  = pm_wdata_q;
        o_tx_data   = tx_data_q;
        o_tx_start  = tx_start_q;
        o_bip_rst   = bip_rst_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_lo_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            lo_q       <= '0;
            pm_addr_q  <= '0;
            pm_wdata_q <= '0;
            counter_q  <= '0;
            status_q   <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            byte_idx_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            bip_rst_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_rx_valid && i_rx_data == CMD_RUN) begin
                        counter_q <= '0;
                        bip_rst_q <= 1'b1;
                    end
                end
                S_LEN_LO: if (i_rx_valid) len_lo_q <= i_rx_data;
                S_LEN_HI: begin
                    if (i_rx_valid) begin
                        len_q <= len_sat;
                        idx_q <= '0;
                    end
                end
                S_DATA_LO: if (i_rx_valid) lo_q <= i_rx_data;
                // Address and data are registered here so they are valid during PM_WR
                // and keep their values afterwards.
                S_DATA_HI: begin
                    if (i_rx_valid) begin
                        pm_addr_q  <= idx_q;
                        pm_wdata_q <= DATA_W'({i_rx_data, lo_q});
                    end
                end
                S_PM_WR: if (!last_word) idx_q <= idx_q + ADDR_W'(1);
                S_RUN: begin
                    if (run_capture) begin
                        status_q   <= i_bip_done ? 8'h00 : 8'hFF;
                        cnt_q      <= counter_q;
                        acc_q      <= i_acc;
                        bip_rst_q  <= 1'b0;
                        byte_idx_q <= '0;
                    end else begin
                        counter_q <= counter_q + CNT_W'(1);
                    end
                end
                S_REPORT: begin
                    if (!i_tx_busy) begin
                        tx_data_q  <= rpt_byte;
                        tx_start_q <= 1'b1;
                    end
                end
                S_TX_WAIT: begin
                    if (!tx_start_q && !i_tx_busy && byte_idx_q != LAST_BYTE)
                        byte_idx_q <= byte_idx_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_run_controller.sv
`timescale 1ns/1ps
module tb_bip_run_controller;

    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 100;
    localparam int PMW     = ADDR_W + DATA_W;

    logic              clk;
    logic              rst;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic [7:0]        o_tx_data;
    logic              o_tx_start;
    logic              i_tx_busy;
    logic              o_pm_we;
    logic [ADDR_W-1:0] o_pm_addr;
    logic [DATA_W-1:0] o_pm_wdata;
    logic              o_bip_rst;
    logic              i_bip_done;
    logic [DATA_W-1:0] i_acc;
    logic              o_busy;
    logic [3:0]        o_dbg_state;

    bip_run_controller #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .i_tx_busy  (i_tx_busy),
        .o_pm_we    (o_pm_we),
        .o_pm_addr  (o_pm_addr),
        .o_pm_wdata (o_pm_wdata),
        .o_bip_rst  (o_bip_rst),
        .i_bip_done (i_bip_done),
        .i_acc      (i_acc),
        .o_busy     (o_busy),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int busy_len = 1;
    int tx_start_cnt = 0;

    logic [7:0]     exp_q[$];
    logic [PMW-1:0] exp_pm_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transmitter model + tx scoreboard ----------------
    initial begin
        logic [7:0] e;
        i_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_start === 1'b1) begin
                tx_start_cnt++;
                if (exp_q.size() == 0) begin
                    check("tx_unexpected", {56'd0, o_tx_data}, 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {56'd0, o_tx_data}, {56'd0, e});
                    i_tx_busy = 1'b1;
                    for (int i = 0; i < busy_len; i++) begin
                        @(negedge clk);
                        check("tx_hold", {56'd0, o_tx_data}, {56'd0, e});
                        check("tx_dup_start", {63'd0, o_tx_start}, 64'd0);
                    end
                    i_tx_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- program-memory monitor ----------------
    initial begin
        logic [PMW-1:0] e;
        forever begin
            @(negedge clk);
            if (o_pm_we === 1'b1) begin
                if (exp_pm_q.size() == 0) begin
                    check("pm_unexpected", {37'd0, o_pm_addr, o_pm_wdata}, 64'hFFFF_FFFF);
                end else begin
                    e = exp_pm_q.pop_front();
                    check("pm_write", {37'd0, o_pm_addr, o_pm_wdata}, {37'd0, e});
                    check("pm_core_held", {63'd0, o_bip_rst}, 64'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 200 && (o_busy || exp_pm_q.size() != 0); c++) @(negedge clk);
        check({name, "_pm_drain"}, 64'(exp_pm_q.size()), 64'd0);
        check({name, "_idle"}, {63'd0, o_busy}, 64'd0);
    endtask

    // Model: N words saturated to the memory depth, written from address 0 upward.
    task automatic do_load(input logic [15:0] n);
        int eff;
        logic [15:0] w;
        eff = (n > (1 << ADDR_W)) ? (1 << ADDR_W) : int'(n);
        send_byte(8'h4C);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < eff; i++) begin
            w = 16'($urandom_range(0, 65535));
            exp_pm_q.push_back({ADDR_W'(i), w});
            send_byte(w[7:0]);
            send_byte(w[15:8]);
        end
        wait_idle("load");
    endtask

    // Model: cnt is the number of RUN cycles before done is seen, or TIMEOUT.
    task automatic do_run(input int k, input bit done_en, input logic [15:0] acc, input bit noise);
        logic [7:0]  status;
        logic [31:0] cnt;
        status = done_en ? 8'h00 : 8'hFF;
        cnt    = done_en ? 32'(k) : 32'(TIMEOUT);
        i_acc  = acc;
        exp_q.push_back(status);
        for (int i = 0; i < 4; i++) exp_q.push_back(cnt[8*i +: 8]);
        exp_q.push_back(acc[7:0]);
        exp_q.push_back(acc[15:8]);
        tx_start_cnt = 0;
        @(negedge clk);
        i_rx_data  = 8'h52;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
        check("bip_rst_rise", {63'd0, o_bip_rst}, 64'd1);
        fork
            begin
                if (done_en) begin
                    repeat (k) @(negedge clk);
                    i_bip_done = 1'b1;
                end
            end
            begin
                if (noise)
                    for (int i = 0; i < 15; i++) send_byte(8'($urandom_range(0, 255)));
            end
        join
        for (int c = 0; c < TIMEOUT + 50 && o_bip_rst; c++) @(negedge clk);
        i_bip_done = 1'b0;
        check("bip_rst_fall", {63'd0, o_bip_rst}, 64'd0);
        for (int c = 0; c < 3000 && (o_busy || exp_q.size() != 0); c++) @(negedge clk);
        check("report_drain", 64'(exp_q.size()), 64'd0);
        check("run_idle", {63'd0, o_busy}, 64'd0);
        check("tx_start_count", 64'(tx_start_cnt), 64'd7);
        check("core_held_after", {63'd0, o_bip_rst}, 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        rst        = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        i_bip_done = 1'b0;
        i_acc      = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {25'd0, o_tx_data, o_tx_start, o_pm_we, o_pm_addr, o_pm_wdata,
              o_bip_rst, o_busy}, 64'd0);
        check("reset_state", {60'd0, o_dbg_state}, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in DATA_HI with a byte arriving in the same cycle.
        send_byte(8'h4C);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        @(negedge clk);
        i_rx_data  = 8'h22;
        i_rx_valid = 1'b1;
        rst        = 1'b0;
        @(negedge clk);
        check("midreset_outputs", {25'd0, o_tx_data, o_tx_start, o_pm_we, o_pm_addr, o_pm_wdata,
              o_bip_rst, o_busy}, 64'd0);
        i_rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_idle", {63'd0, o_busy}, 64'd0);
        do_run(3, 1'b1, 16'h1234, 1'b0);

        // Fixed load example.
        exp_pm_q.push_back({11'd0, 16'h2211});
        exp_pm_q.push_back({11'd1, 16'h4433});
        exp_pm_q.push_back({11'd2, 16'h6655});
        send_byte(8'h4C); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
        wait_idle("fixed_load");
        check("pm_hold", {37'd0, o_pm_addr, o_pm_wdata}, {37'd0, 11'd2, 16'h6655});

        // Fixed run, then timeout with rx noise during the run.
        do_run(5, 1'b1, 16'hBEEF, 1'b0);
        do_run(0, 1'b0, 16'($urandom_range(0, 65535)), 1'b1);

        // Backpressure.
        busy_len = 20;
        do_run(int'($urandom_range(1, 40)), 1'b1, 16'($urandom_range(0, 65535)), 1'b0);
        busy_len = 1;

        // Noise in IDLE.
        send_byte(8'h00);
        send_byte(8'hFF);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            if (b == 8'h4C || b == 8'h52) b = 8'h01;
            send_byte(b);
        end
        @(negedge clk);
        check("noise_idle", {62'd0, o_busy, o_bip_rst}, 64'd0);

        // Limits and random traffic.
        do_load(16'd0);
        do_load(16'(($urandom_range(1, 9))));
        for (int r = 0; r < 3; r++) begin
            busy_len = int'($urandom_range(1, 4));
            do_run(int'($urandom_range(1, TIMEOUT - 1)), 1'b1, 16'($urandom_range(0, 65535)), 1'b0);
        end
        busy_len = 1;
        do_load(16'hFFFF);
        check("pm_last_addr", {53'd0, o_pm_addr}, 64'h7FF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
